// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the core datapath.
// Holds the default sizing constants, core-wide address/data types and the
// architectural zero-register index.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus for the multi-port register file.
//   ra        : NRD read addresses
//   rd        : NRD read data
//   rd_busy   : NRD scoreboard busy bits for the read addresses
//   we/wa/wd  : NWR write enables, addresses and data
//   iss_valid : an instruction issues that will write iss_rd
//   iss_rd    : destination of the issuing instruction
// master drives requests (decode + writeback), slave is the register file.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][XLEN-1:0] rd;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           we;
    logic [NWR-1:0][AW-1:0]   wa;
    logic [NWR-1:0][XLEN-1:0] wd;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;

    modport master (
        output ra, we, wa, wd, iss_valid, iss_rd,
        input  rd, rd_busy
    );

    modport slave (
        input  ra, we, wa, wd, iss_valid, iss_rd,
        output rd, rd_busy
    );

endinterface

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard for RAW hazard detection.
//   clk, reset  : clock, synchronous active-high reset
//   set_valid_i : mark set_addr_i busy on this edge
//   set_addr_i  : register being claimed by an issuing instruction
//   clr_en_i    : per write port, clear clr_addr_i busy on this edge
//   clr_addr_i  : per write port, register being written back
//   busy_o      : busy vector, bit 0 always 0
// A set and a clear of the same register in one cycle leaves it busy: the
// newly issued producer owns the register.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 1,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_valid_i,
    input  logic [AW-1:0]          set_addr_i,
    input  logic [NWR-1:0]         clr_en_i,
    input  logic [NWR-1:0][AW-1:0] clr_addr_i,
    output logic [NREGS-1:0]       busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (clr_en_i[k]) begin
                busy_d[clr_addr_i[k]] = 1'b0;
            end
        end
        // Set applied after clears so it takes priority.
        if (set_valid_i && set_addr_i != AW'(REG_ZERO)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, multi-write integer register file with busy scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_mp_if slave (reads, writes, issue)
// Reads are combinational. Writes land on the rising edge; with BYPASS=1 a
// read of an address being written this cycle returns the write data and
// masks its busy bit. Register 0 reads 0, is never busy, has no storage.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);

    logic [XLEN-1:0]  mem_q    [NREGS-1:1];
    logic [XLEN-1:0]  mem_d    [NREGS-1:1];
    logic [XLEN-1:0]  mem_view [NREGS];
    logic [NREGS-1:0] busy;

    // Ports are scanned low to high so the highest-indexed write wins.
    always_comb begin
        for (int unsigned r = 1; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
            for (int unsigned k = 0; k < NWR; k++) begin
                if (bus.we[k] && bus.wa[k] == AW'(r)) begin
                    mem_d[r] = bus.wd[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    always_comb begin
        mem_view[REG_ZERO] = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            mem_view[r] = mem_q[r];
        end
    end

    regfile_sb #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .set_valid_i (bus.iss_valid),
        .set_addr_i  (bus.iss_rd),
        .clr_en_i    (bus.we),
        .clr_addr_i  (bus.wa),
        .busy_o      (busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] rd_val;
        logic            hit;

        always_comb begin
            hit    = 1'b0;
            rd_val = mem_view[bus.ra[i]];
            if (BYPASS != 0 && bus.ra[i] != AW'(REG_ZERO)) begin
                for (int unsigned k = 0; k < NWR; k++) begin
                    if (bus.we[k] && bus.wa[k] == bus.ra[i]) begin
                        hit    = 1'b1;
                        rd_val = bus.wd[k];
                    end
                end
            end
        end

        assign bus.rd[i]      = rd_val;
        // A forwarded value satisfies the hazard, so decode need not stall.
        assign bus.rd_busy[i] = busy[bus.ra[i]] & ~hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // dut_a: dual write, bypass on. dut_b: single write, bypass off.
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) bus_b ();

    regfile_mp #(
        .XLEN   (32),
        .NREGS  (32),
        .NRD    (2),
        .NWR    (2),
        .BYPASS (1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_mp #(
        .XLEN   (32),
        .NREGS  (32),
        .NRD    (2),
        .NWR    (1),
        .BYPASS (0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Port-0 write, driven identically on both buses.
    task automatic wr0(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus_a.we[0] = en;
        bus_a.wa[0] = a;
        bus_a.wd[0] = d;
        bus_b.we[0] = en;
        bus_b.wa[0] = a;
        bus_b.wd[0] = d;
    endtask

    task automatic rda(input logic [4:0] a0, input logic [4:0] a1);
        bus_a.ra[0] = a0;
        bus_a.ra[1] = a1;
        bus_b.ra[0] = a0;
        bus_b.ra[1] = a1;
    endtask

    task automatic iss(input logic v, input logic [4:0] a);
        bus_a.iss_valid = v;
        bus_a.iss_rd    = a;
        bus_b.iss_valid = v;
        bus_b.iss_rd    = a;
    endtask

    initial begin
        reset = 1'b1;
        bus_a.we = '0;
        bus_a.wa = '0;
        bus_a.wd = '0;
        wr0(1'b0, 5'd0, 32'h0);
        rda(5'd5, 5'd31);
        iss(1'b0, 5'd0);
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check_val("rst_rd0_a", bus_a.rd[0], 32'h0);
        check_val("rst_rd1_a", bus_a.rd[1], 32'h0);
        check_val("rst_bsy0_a", {31'b0, bus_a.rd_busy[0]}, 32'h0);
        check_val("rst_bsy1_a", {31'b0, bus_a.rd_busy[1]}, 32'h0);
        check_val("rst_rd0_b", bus_b.rd[0], 32'h0);

        // Plain write then read
        wr0(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr0(1'b0, 5'd0, 32'h0);
        rda(5'd5, 5'd0);
        #1;
        check_val("wr5_a", bus_a.rd[0], 32'hDEADBEEF);
        check_val("wr5_b", bus_b.rd[0], 32'hDEADBEEF);

        // Writes to x0 are dropped, also not forwarded
        wr0(1'b1, 5'd0, 32'h00001234);
        rda(5'd5, 5'd0);
        #1;
        check_val("x0_during_a", bus_a.rd[1], 32'h0);
        tick();
        wr0(1'b0, 5'd0, 32'h0);
        #1;
        check_val("x0_after_a", bus_a.rd[1], 32'h0);
        check_val("x0_after_b", bus_b.rd[1], 32'h0);

        // Bypass on vs off
        wr0(1'b1, 5'd7, 32'hA5A5A5A5);
        rda(5'd7, 5'd5);
        #1;
        check_val("byp_on_a", bus_a.rd[0], 32'hA5A5A5A5);
        check_val("byp_off_b", bus_b.rd[0], 32'h0);
        check_val("byp_other_port", bus_a.rd[1], 32'hDEADBEEF);
        tick();
        wr0(1'b0, 5'd0, 32'h0);
        #1;
        check_val("byp_post_a", bus_a.rd[0], 32'hA5A5A5A5);
        check_val("byp_post_b", bus_b.rd[0], 32'hA5A5A5A5);

        // Dual write to same address: port 1 wins (bypass and storage)
        bus_a.we    = 2'b11;
        bus_a.wa[0] = 5'd9;
        bus_a.wa[1] = 5'd9;
        bus_a.wd[0] = 32'h11;
        bus_a.wd[1] = 32'h22;
        rda(5'd9, 5'd9);
        #1;
        check_val("dual_byp", bus_a.rd[0], 32'h22);
        tick();
        // Dual write to different addresses: both land
        bus_a.wa[0] = 5'd10;
        bus_a.wa[1] = 5'd11;
        bus_a.wd[0] = 32'h33;
        bus_a.wd[1] = 32'h44;
        tick();
        bus_a.we = '0;
        rda(5'd9, 5'd10);
        #1;
        check_val("dual_same", bus_a.rd[0], 32'h22);
        check_val("dual_p0", bus_a.rd[1], 32'h33);
        rda(5'd11, 5'd9);
        #1;
        check_val("dual_p1", bus_a.rd[0], 32'h44);

        // Scoreboard: issue sets busy
        iss(1'b1, 5'd3);
        tick();
        iss(1'b0, 5'd0);
        rda(5'd3, 5'd7);
        #1;
        check_val("sb_set_a", {31'b0, bus_a.rd_busy[0]}, 32'h1);
        check_val("sb_set_b", {31'b0, bus_b.rd_busy[0]}, 32'h1);
        check_val("sb_other", {31'b0, bus_a.rd_busy[1]}, 32'h0);

        // Writeback to 3: masked with bypass, not without
        wr0(1'b1, 5'd3, 32'h55);
        #1;
        check_val("sb_mask_a", {31'b0, bus_a.rd_busy[0]}, 32'h0);
        check_val("sb_fwd_a", bus_a.rd[0], 32'h55);
        check_val("sb_nomask_b", {31'b0, bus_b.rd_busy[0]}, 32'h1);
        tick();
        wr0(1'b0, 5'd0, 32'h0);
        #1;
        check_val("sb_clr_a", {31'b0, bus_a.rd_busy[0]}, 32'h0);
        check_val("sb_clr_b", {31'b0, bus_b.rd_busy[0]}, 32'h0);
        check_val("sb_data_a", bus_a.rd[0], 32'h55);

        // Issue to x0 never sets busy
        iss(1'b1, 5'd0);
        tick();
        iss(1'b0, 5'd0);
        rda(5'd0, 5'd3);
        #1;
        check_val("sb_x0", {31'b0, bus_a.rd_busy[0]}, 32'h0);

        // Set/clear collision: set wins
        iss(1'b1, 5'd4);
        wr0(1'b1, 5'd4, 32'h66);
        tick();
        iss(1'b0, 5'd0);
        wr0(1'b0, 5'd0, 32'h0);
        rda(5'd4, 5'd0);
        #1;
        check_val("coll_bsy_a", {31'b0, bus_a.rd_busy[0]}, 32'h1);
        check_val("coll_bsy_b", {31'b0, bus_b.rd_busy[0]}, 32'h1);
        check_val("coll_data_a", bus_a.rd[0], 32'h66);

        // Reset mid-op: issue and write ignored, everything clears
        reset = 1'b1;
        iss(1'b1, 5'd6);
        wr0(1'b1, 5'd8, 32'h77);
        tick();
        reset = 1'b0;
        iss(1'b0, 5'd0);
        wr0(1'b0, 5'd0, 32'h0);
        rda(5'd4, 5'd6);
        #1;
        check_val("mrst_bsy4", {31'b0, bus_a.rd_busy[0]}, 32'h0);
        check_val("mrst_bsy6", {31'b0, bus_a.rd_busy[1]}, 32'h0);
        check_val("mrst_bsy4_b", {31'b0, bus_b.rd_busy[0]}, 32'h0);
        rda(5'd5, 5'd8);
        #1;
        check_val("mrst_mem5", bus_a.rd[0], 32'h0);
        check_val("mrst_mem8", bus_a.rd[1], 32'h0);
        check_val("mrst_mem5_b", bus_b.rd[0], 32'h0);
        rda(5'd9, 5'd4);
        #1;
        check_val("mrst_mem9", bus_a.rd[0], 32'h0);
        check_val("mrst_mem4", bus_a.rd[1], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
